// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit:
// states, opcode/function fields, ALU codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_BRT  = 2'b11;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_ALUR = 2'b01;
    localparam logic [1:0] PCS_RA   = 2'b10;
    localparam logic [1:0] PCS_JUMP = 2'b11;

    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_jr;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_lui;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_j;
        logic i_jal;
    } inst_t;

    function automatic logic [3:0] alu_code(inst_t d);
        logic [3:0] c;
        c = ALUC_ADD;
        unique case (1'b1)
            d.i_sub, d.i_beq, d.i_bne: c = ALUC_SUB;
            d.i_and, d.i_andi:         c = ALUC_AND;
            d.i_or,  d.i_ori:          c = ALUC_OR;
            d.i_xor, d.i_xori:         c = ALUC_XOR;
            d.i_lui:                   c = ALUC_LUI;
            d.i_sll:                   c = ALUC_SLL;
            d.i_srl:                   c = ALUC_SRL;
            d.i_sra:                   c = ALUC_SRA;
            default:                   c = ALUC_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decode into one-hot instruction classes.
// Anything outside the supported subset raises ill.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output inst_t      d,
    output logic       ill
);

    logic r;

    assign r = (op == OP_RTYPE);

    always_comb begin
        d        = '0;
        d.i_add  = r && (func == FN_ADD);
        d.i_sub  = r && (func == FN_SUB);
        d.i_and  = r && (func == FN_AND);
        d.i_or   = r && (func == FN_OR);
        d.i_xor  = r && (func == FN_XOR);
        d.i_sll  = r && (func == FN_SLL);
        d.i_srl  = r && (func == FN_SRL);
        d.i_sra  = r && (func == FN_SRA);
        d.i_jr   = r && (func == FN_JR);
        d.i_addi = (op == OP_ADDI);
        d.i_andi = (op == OP_ANDI);
        d.i_ori  = (op == OP_ORI);
        d.i_xori = (op == OP_XORI);
        d.i_lui  = (op == OP_LUI);
        d.i_lw   = (op == OP_LW);
        d.i_sw   = (op == OP_SW);
        d.i_beq  = (op == OP_BEQ);
        d.i_bne  = (op == OP_BNE);
        d.i_j    = (op == OP_J);
        d.i_jal  = (op == OP_JAL);
    end

    assign ill = (d == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences IF/ID/EXE/MEM/WB and drives
// every datapath write enable and mux select.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int SW_ILL_TRAP = 0
)(
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic [2:0] q,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       sext,
    output logic       shift,
    output logic       alusela,
    output logic [1:0] aluselb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic       retire,
    output logic       ill
);

    state_t st;
    state_t nst;
    logic   ill_q;
    logic   set_ill;
    inst_t  d;
    logic   d_ill;
    logic   shf;
    logic   rtype;
    logic   itype;
    logic   br;
    logic   wpc_c;
    logic   wir_c;
    logic   wmem_c;
    logic   wreg_c;
    logic   ret_c;

    mc_decode u_dec (
        .op   (op),
        .func (func),
        .d    (d),
        .ill  (d_ill)
    );

    assign shf   = d.i_sll | d.i_srl | d.i_sra;
    assign rtype = d.i_add | d.i_sub | d.i_and | d.i_or
                 | d.i_xor | shf | d.i_jr;
    assign itype = d.i_addi | d.i_andi | d.i_ori | d.i_xori
                 | d.i_lui | d.i_lw;
    assign br    = d.i_beq | d.i_bne;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st    <= S_IF;
            ill_q <= 1'b0;
        end else begin
            st    <= nst;
            ill_q <= ill_q | set_ill;
        end
    end

    always_comb begin
        nst     = S_IF;
        set_ill = 1'b0;
        unique case (st)
            S_IF:  nst = mem_ready ? S_ID : S_IF;
            S_ID: begin
                if (d_ill) begin
                    set_ill = 1'b1;
                    nst     = (SW_ILL_TRAP != 0) ? S_ID : S_IF;
                end else if (d.i_j | d.i_jal | d.i_jr) begin
                    nst = S_IF;
                end else begin
                    nst = S_EXE;
                end
            end
            S_EXE: begin
                if (br)
                    nst = S_IF;
                else if (d.i_lw | d.i_sw)
                    nst = S_MEM;
                else
                    nst = S_WB;
            end
            S_MEM: begin
                if (!mem_ready)
                    nst = S_MEM;
                else if (d.i_lw)
                    nst = S_WB;
                else
                    nst = S_IF;
            end
            S_WB:    nst = S_IF;
            default: nst = S_IF;
        endcase
    end

    // Defaults are the fetch-cycle selects, so reset and
    // unused encodings present IF muxes with no writes.
    always_comb begin
        wpc_c    = 1'b0;
        wir_c    = 1'b0;
        wmem_c   = 1'b0;
        wreg_c   = 1'b0;
        ret_c    = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        shift    = 1'b0;
        alusela  = 1'b0;
        aluselb  = ALUB_FOUR;
        aluc     = ALUC_ADD;
        pcsource = PCS_ALU;
        unique case (st)
            S_IF: begin
                wpc_c = mem_ready;
                wir_c = mem_ready;
            end
            S_ID: begin
                aluselb = ALUB_BRT;
                unique case (1'b1)
                    d_ill: ret_c = (SW_ILL_TRAP == 0);
                    d.i_j, d.i_jal: begin
                        pcsource = PCS_JUMP;
                        wpc_c    = 1'b1;
                        ret_c    = 1'b1;
                        wreg_c   = d.i_jal;
                        jal      = d.i_jal;
                    end
                    d.i_jr: begin
                        pcsource = PCS_RA;
                        wpc_c    = 1'b1;
                        ret_c    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXE: begin
                alusela = 1'b1;
                shift   = shf;
                aluselb = rtype ? ALUB_REG : ALUB_IMM;
                sext    = d.i_addi | d.i_lw | d.i_sw | br;
                aluc    = alu_code(d);
                if (br) begin
                    pcsource = PCS_ALUR;
                    wpc_c    = d.i_beq ? z : ~z;
                    ret_c    = 1'b1;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                wmem_c = d.i_sw;
                ret_c  = d.i_sw & mem_ready;
            end
            S_WB: begin
                wreg_c = 1'b1;
                ret_c  = 1'b1;
                regrt  = itype;
                m2reg  = d.i_lw;
            end
            default: ;
        endcase
    end

    assign wpc    = wpc_c  & clrn;
    assign wir    = wir_c  & clrn;
    assign wmem   = wmem_c & clrn;
    assign wreg   = wreg_c & clrn;
    assign retire = ret_c  & clrn;
    assign q      = st;
    assign ill    = ill_q;

endmodule
